alu_server: RTL

ALU_SERVER -- requirements
Module: alu_server

---
 rtl/alu_server.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_server.sv
`default_nettype none

// ============================================================================
//  Module      : alu_server
//  Description : Round-robin shared saturating ADD/SUB/fixed-point-MUL unit
//                serving NCLI request/echo client ports.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef PID_RES
`define PID_RES 32
`endif
`ifndef KEY_SIZE
`define KEY_SIZE 8
`endif
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 2
`endif
`ifndef ADD
`define ADD 2'd0
`endif
`ifndef SUB
`define SUB 2'd1
`endif
`ifndef MUL
`define MUL 2'd2
`endif

module alu_server #(
    parameter int nbits = `PID_RES,
    parameter int NCLI  = 2,
    parameter int FRAC  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCLI*`KEY_SIZE-1:0]     req_key_i,
    input  logic [NCLI*`OPCODE_SIZE-1:0]  req_op_i,
    input  logic [NCLI*nbits-1:0]         req_A_i,
    input  logic [NCLI*nbits-1:0]         req_B_i,
    output logic [NCLI*`KEY_SIZE-1:0]     rsp_key_o,
    output logic [NCLI*nbits-1:0]         rsp_O_o
);

    localparam int c_KS = `KEY_SIZE;
    localparam int c_OS = `OPCODE_SIZE;
    localparam int c_IW = (NCLI > 1) ? $clog2(NCLI) : 1;

    localparam logic [nbits-1:0] c_MAX = {1'b0, {(nbits-1){1'b1}}};
    localparam logic [nbits-1:0] c_MIN = {1'b1, {(nbits-1){1'b0}}};

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd1;
    localparam logic [2:0] S_MUL1 = 3'd2;
    localparam logic [2:0] S_MUL2 = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]                  r_state;
    logic [2:0]                  w_next;
    logic [c_IW-1:0]             r_start;
    logic [c_IW-1:0]             r_gnt;
    logic [c_KS-1:0]             r_key;
    logic [c_OS-1:0]             r_op;
    logic [nbits-1:0]            r_a;
    logic [nbits-1:0]            r_b;
    logic [nbits-1:0]            r_res;
    logic signed [2*nbits-1:0]   r_prod;
    logic [NCLI*c_KS-1:0]        r_rsp_key;
    logic [NCLI*nbits-1:0]       r_rsp_o;

    logic [NCLI-1:0]             w_pend;
    logic                        w_found;
    logic [c_IW-1:0]             w_sel;
    logic                        w_grant;
    logic                        w_do_exec;
    logic                        w_do_mul1;
    logic                        w_do_mul2;
    logic                        w_do_resp;

    // A port is pending while its tag is non-zero and not yet echoed back.
    generate
        for (genvar p = 0; p < NCLI; p++) begin : g_pend
            assign w_pend[p] = (req_key_i[p*c_KS +: c_KS] != '0) &&
                               (req_key_i[p*c_KS +: c_KS] != r_rsp_key[p*c_KS +: c_KS]);
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < NCLI; i++) begin
            int j;
            j = int'(r_start) + i;
            if (j >= NCLI) begin
                j = j - NCLI;
            end
            if (!w_found && w_pend[c_IW'(j)]) begin
                w_found = 1'b1;
                w_sel   = c_IW'(j);
            end
        end
    end

    // Add/subtract one bit wider than the operands so overflow is visible.
    logic [nbits:0]   w_sum;
    logic [nbits-1:0] w_alu;
    always_comb begin
        w_sum = '0;
        case (r_op)
            `ADD:    w_sum = {r_a[nbits-1], r_a} + {r_b[nbits-1], r_b};
            `SUB:    w_sum = {r_a[nbits-1], r_a} - {r_b[nbits-1], r_b};
            default: w_sum = '0;
        endcase
        if (w_sum[nbits] != w_sum[nbits-1]) begin
            w_alu = w_sum[nbits] ? c_MIN : c_MAX;
        end else begin
            w_alu = w_sum[nbits-1:0];
        end
    end

    logic signed [2*nbits-1:0] w_a_ext;
    logic signed [2*nbits-1:0] w_b_ext;
    logic signed [2*nbits-1:0] w_prod;
    logic signed [2*nbits-1:0] w_shr;
    logic [nbits:0]            w_hi;
    logic [nbits-1:0]          w_mul_sat;

    assign w_a_ext = {{nbits{r_a[nbits-1]}}, r_a};
    assign w_b_ext = {{nbits{r_b[nbits-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_shr   = r_prod >>> FRAC;
    assign w_hi    = w_shr[2*nbits-1:nbits-1];

    // The shifted product fits only when its top nbits+1 bits are a pure sign run.
    always_comb begin
        if ((&w_hi) || !(|w_hi)) begin
            w_mul_sat = w_shr[nbits-1:0];
        end else begin
            w_mul_sat = w_shr[2*nbits-1] ? c_MIN : c_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = (req_op_i[w_sel*c_OS +: c_OS] == `MUL) ? S_MUL1 : S_EXEC;
                end
            end
            S_EXEC:  w_next = S_RESP;
            S_MUL1:  w_next = S_MUL2;
            S_MUL2:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant   = (r_state == S_IDLE) && w_found;
        w_do_exec = (r_state == S_EXEC);
        w_do_mul1 = (r_state == S_MUL1);
        w_do_mul2 = (r_state == S_MUL2);
        w_do_resp = (r_state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start   <= '0;
            r_gnt     <= '0;
            r_key     <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_prod    <= '0;
            r_rsp_key <= '0;
            r_rsp_o   <= '0;
        end else begin
            if (w_grant) begin
                r_gnt <= w_sel;
                r_key <= req_key_i[w_sel*c_KS +: c_KS];
                r_op  <= req_op_i[w_sel*c_OS +: c_OS];
                r_a   <= req_A_i[w_sel*nbits +: nbits];
                r_b   <= req_B_i[w_sel*nbits +: nbits];
            end
            if (w_do_exec) begin
                r_res <= w_alu;
            end
            if (w_do_mul1) begin
                r_prod <= w_prod;
            end
            if (w_do_mul2) begin
                r_res <= w_mul_sat;
            end
            if (w_do_resp) begin
                r_rsp_key[r_gnt*c_KS +: c_KS] <= r_key;
                r_rsp_o[r_gnt*nbits +: nbits] <= r_res;
                r_start <= (r_gnt == c_IW'(NCLI-1)) ? '0 : r_gnt + c_IW'(1);
            end
        end
    end

    assign rsp_key_o = r_rsp_key;
    assign rsp_O_o   = r_rsp_o;

endmodule

`default_nettype wire
